mvu_seq: RTL
============

# mvu_seq

Per-MVU job sequencer: the initiator that drives one MVU core's compute-control and data-bank access ports (mul_mode, acc_clr, acc_sh, rdw_addr, rdd_*, wrd_*) from a single job descriptor. It sits between the host/job controller and one `mvuarray` slot of the top level, with one instance per MVU. For each output word it walks the bit-serial iterations, aligns accumulator control to the MVU datapath latency, and writes the result back to the data bank.

## Interface
- NMVU_LAT, 3, MVU read-to-accumulator latency in cycles (≥1)
- BWBANKA, 9, weight bank address width
- BDBANKA, 15, data bank address width
- BLEN, 10, output-word count width
- BITER, 4, iteration count width

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  job start pulse, sampled in IDLE only
- cfg_mode  in  2  mul_mode applied to valid iterations
- cfg_iters  in  BITER  iterations per output word
- cfg_len  in  BLEN  output words in job
- cfg_waddr  in  BWBANKA  first weight address
- cfg_daddr  in  BDBANKA  first data address
- cfg_oaddr  in  BDBANKA  first output address
- cfg_busy  out  1  job in progress
- cfg_done  out  1  one-cycle job-complete pulse
- mul_mode  out  2  to MVU
- acc_clr  out  1  to MVU
- acc_sh  out  1  to MVU
- rdw_addr  out  BWBANKA  weight read address
- rdd_en  out  1  data read request
- rdd_grnt  in  1  data read grant
- rdd_addr  out  BDBANKA  data read address
- wrd_en  out  1  data write request
- wrd_grnt  in  1  data write grant
- wrd_addr  out  BDBANKA  data write address

## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: on cfg_start, latch the descriptor, set k=0, j=0, wptr=cfg_waddr, and go to READ. If cfg_iters==0 or cfg_len==0, go directly to DONE with no MVU traffic.
- READ: rdd_en=1, rdd_addr=cfg_daddr+j (mod 2^BDBANKA), rdw_addr=wptr.
  - A read counts only in a cycle with rdd_en&rdd_grnt. On a counted read, wptr++ (mod 2^BWBANKA) and j++.
  - On the last counted read (j==iters-1), go to DRAIN.
  - Without a grant, addresses hold.
- Control delay pipe: NMVU_LAT stages, pushed every cycle.
  - Counted read: {cfg_mode, clr=(j==0), sh=(j!=0)}.
  - Any other cycle (bubble): {2'b00, 0, 0}, where 00 is the zero-product mode.
  - Pipe output drives mul_mode/acc_clr/acc_sh directly.
- DRAIN: wait until the entry for the last read has been presented at the outputs, then go to WRITE.
- WRITE: wrd_en=1, wrd_addr=cfg_oaddr+k (mod 2^BDBANKA), held until wrd_grnt.
  - On grant: if k==len-1, go to DONE; otherwise k++, j=0, go to READ. wptr continues; it does not reset per word.
- DONE: cfg_done=1 for one cycle, then IDLE.
- cfg_busy=1 in every state except IDLE.
- cfg_start outside IDLE is ignored.

## Timing
- Reset (async): state IDLE; all outputs 0, including mul_mode=00; pipe cleared; counters 0.
- Reset mid-job: the job is abandoned immediately and no cfg_done is issued.
- cfg_start sampled at edge t → READ (rdd_en high) in cycle t+1.
- A counted read in cycle c → its control entry is on mul_mode/acc_clr/acc_sh in cycle c+NMVU_LAT.
- Last read in cycle c → wrd_en first high in cycle c+NMVU_LAT+1.
- Write granted in cycle w (last word) → cfg_done=1 and cfg_busy=1 in cycle w+1; cfg_busy=0 from w+2.
- rdd_en and wrd_en are never high in the same cycle.
- Request signals do not depend combinationally on grants; grants only affect the next state.

## Structure
- Package mvu_seq_pkg holds:
  - the state enum
  - MUL_MODE_OFF=2'b00
  - default widths BWBANKA, BDBANKA
  - the control-entry struct {mode, clr, sh}
- Sub-module mvu_seq_dly: parameterised NMVU_LAT-deep shift register of control entries, with async clear.

## Test plan
- NMVU_LAT=3, len=1, iters=1, grants tied high, start at edge 0 → rdd_en in cycle 1 at cfg_daddr; acc_clr=1 and mul_mode=cfg_mode in cycle 4; wrd_en in cycle 5 at cfg_oaddr; cfg_done in cycle 6; cfg_busy low from cycle 7.
- len=2, iters=4, cfg_waddr=510 → rdw_addr sequence 510,511,0,1,2,3,4,5; rdd_addr repeats daddr..daddr+3 for each word; per word one acc_clr then three acc_sh; wrd_addr = oaddr, then oaddr+1.
- rdd_grnt low for 2 cycles during j=1 → address held for those 2 cycles; 2 bubble entries (mode 00, clr/sh 0) appear at the outputs 3 cycles later; totals of 1 clr and 3 sh are unchanged.
- wrd_grnt withheld 5 cycles → wrd_en and wrd_addr stable for 6 cycles; cfg_done only in the cycle after the grant.
- rst pulsed during READ of word 1 → all outputs 0 asynchronously, no cfg_done; a fresh start then runs the new job correctly from k=0.
- cfg_iters=0 → cfg_done one cycle after IDLE exit, with no rdd_en/wrd_en. A cfg_start during a busy job → ignored, and the job's outputs are unchanged.

Source files
------------

// File: rtl/mvu_seq_pkg.sv
// Shared types and defaults for the per-MVU job sequencer.
package mvu_seq_pkg;

    localparam int unsigned BWBANKA = 9;
    localparam int unsigned BDBANKA = 15;

    localparam logic [1:0] MUL_MODE_OFF = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [1:0] mode;
        logic       clr;
        logic       sh;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{mode: MUL_MODE_OFF, clr: 1'b0, sh: 1'b0};

endpackage

// File: rtl/mvu_seq_dly.sv
// Fixed-depth delay line that lines accumulator control up with the MVU datapath.
module mvu_seq_dly
    import mvu_seq_pkg::*;
#(
    parameter int unsigned NMVU_LAT = 3
) (
    input  logic  clk,
    input  logic  rst,
    input  ctrl_t din,
    output ctrl_t dout
);

    ctrl_t pipe [NMVU_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NMVU_LAT); i++) pipe[i] <= CTRL_BUBBLE;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < int'(NMVU_LAT); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[NMVU_LAT-1];

endmodule

// File: rtl/mvu_seq.sv
// Job sequencer for one MVU: walks bit-serial reads per output word, delays
// accumulator control by the datapath latency, then writes the word back.
module mvu_seq #(
    parameter int unsigned NMVU_LAT = 3,
    parameter int unsigned BWBANKA  = mvu_seq_pkg::BWBANKA,
    parameter int unsigned BDBANKA  = mvu_seq_pkg::BDBANKA,
    parameter int unsigned BLEN     = 10,
    parameter int unsigned BITER    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [1:0]         cfg_mode,
    input  logic [BITER-1:0]   cfg_iters,
    input  logic [BLEN-1:0]    cfg_len,
    input  logic [BWBANKA-1:0] cfg_waddr,
    input  logic [BDBANKA-1:0] cfg_daddr,
    input  logic [BDBANKA-1:0] cfg_oaddr,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic [1:0]         mul_mode,
    output logic               acc_clr,
    output logic               acc_sh,
    output logic [BWBANKA-1:0] rdw_addr,
    output logic               rdd_en,
    input  logic               rdd_grnt,
    output logic [BDBANKA-1:0] rdd_addr,
    output logic               wrd_en,
    input  logic               wrd_grnt,
    output logic [BDBANKA-1:0] wrd_addr
);
    import mvu_seq_pkg::*;

    localparam int unsigned DW = (NMVU_LAT > 1) ? $clog2(NMVU_LAT) : 1;

    state_e             state_q, state_nxt;
    logic [BITER-1:0]   j_q, j_nxt, iters_q, iters_nxt;
    logic [BLEN-1:0]    k_q, k_nxt, len_q, len_nxt;
    logic [BWBANKA-1:0] wptr_q, wptr_nxt;
    logic [DW-1:0]      dcnt_q, dcnt_nxt;
    logic [1:0]         mode_q, mode_nxt;
    logic [BDBANKA-1:0] daddr_q, daddr_nxt, oaddr_q, oaddr_nxt;

    logic               busy_d, done_d, rdd_en_d, wrd_en_d;
    logic [BWBANKA-1:0] rdw_addr_d;
    logic [BDBANKA-1:0] rdd_addr_d, wrd_addr_d;

    logic  rd_fire;
    ctrl_t ctrl_push, ctrl_out;

    assign rd_fire = rdd_en && rdd_grnt;

    // State, counters, descriptor and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            j_q      <= '0;
            k_q      <= '0;
            wptr_q   <= '0;
            dcnt_q   <= '0;
            mode_q   <= MUL_MODE_OFF;
            iters_q  <= '0;
            len_q    <= '0;
            daddr_q  <= '0;
            oaddr_q  <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
            rdd_en   <= 1'b0;
            rdd_addr <= '0;
            rdw_addr <= '0;
            wrd_en   <= 1'b0;
            wrd_addr <= '0;
        end else begin
            state_q  <= state_nxt;
            j_q      <= j_nxt;
            k_q      <= k_nxt;
            wptr_q   <= wptr_nxt;
            dcnt_q   <= dcnt_nxt;
            mode_q   <= mode_nxt;
            iters_q  <= iters_nxt;
            len_q    <= len_nxt;
            daddr_q  <= daddr_nxt;
            oaddr_q  <= oaddr_nxt;
            cfg_busy <= busy_d;
            cfg_done <= done_d;
            rdd_en   <= rdd_en_d;
            rdd_addr <= rdd_addr_d;
            rdw_addr <= rdw_addr_d;
            wrd_en   <= wrd_en_d;
            wrd_addr <= wrd_addr_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_nxt = state_q;
        j_nxt     = j_q;
        k_nxt     = k_q;
        wptr_nxt  = wptr_q;
        dcnt_nxt  = dcnt_q;
        mode_nxt  = mode_q;
        iters_nxt = iters_q;
        len_nxt   = len_q;
        daddr_nxt = daddr_q;
        oaddr_nxt = oaddr_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    mode_nxt  = cfg_mode;
                    iters_nxt = cfg_iters;
                    len_nxt   = cfg_len;
                    daddr_nxt = cfg_daddr;
                    oaddr_nxt = cfg_oaddr;
                    j_nxt     = '0;
                    k_nxt     = '0;
                    wptr_nxt  = cfg_waddr;
                    state_nxt = (cfg_iters == '0 || cfg_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_fire) begin
                    wptr_nxt = wptr_q + BWBANKA'(1);
                    j_nxt    = j_q + BITER'(1);
                    if (j_q == iters_q - BITER'(1)) begin
                        state_nxt = S_DRAIN;
                        dcnt_nxt  = '0;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the last read's control entry is on the outputs
                if (dcnt_q == DW'(NMVU_LAT - 1)) state_nxt = S_WRITE;
                else                             dcnt_nxt  = dcnt_q + DW'(1);
            end
            S_WRITE: begin
                if (wrd_grnt) begin
                    if (k_q == len_q - BLEN'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        k_nxt     = k_q + BLEN'(1);
                        j_nxt     = '0;
                        state_nxt = S_READ;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        busy_d     = (state_nxt != S_IDLE);
        done_d     = (state_nxt == S_DONE);
        rdd_en_d   = (state_nxt == S_READ);
        wrd_en_d   = (state_nxt == S_WRITE);
        rdd_addr_d = '0;
        rdw_addr_d = '0;
        wrd_addr_d = '0;
        if (rdd_en_d) begin
            rdd_addr_d = daddr_nxt + BDBANKA'(j_nxt);
            rdw_addr_d = wptr_nxt;
        end
        if (wrd_en_d) wrd_addr_d = oaddr_nxt + BDBANKA'(k_nxt);
    end

    // Counted reads push real control; every other cycle pushes a bubble
    always_comb begin
        ctrl_push = CTRL_BUBBLE;
        if (rd_fire) begin
            ctrl_push.mode = mode_q;
            ctrl_push.clr  = (j_q == '0);
            ctrl_push.sh   = (j_q != '0);
        end
    end

    mvu_seq_dly #(
        .NMVU_LAT(NMVU_LAT)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .din (ctrl_push),
        .dout(ctrl_out)
    );

    assign mul_mode = ctrl_out.mode;
    assign acc_clr  = ctrl_out.clr;
    assign acc_sh   = ctrl_out.sh;

endmodule
